// File: rtl/mem_arb_pkg.sv
// Shared types for the IFU/LSU memory arbiter: FSM states, owner ids and
// the byte-mask width derivation.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

  localparam int BYTE_W = 8;

  function automatic int mask_width(input int data_w);
    return data_w / BYTE_W;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins, and a tie goes to
// whichever side was not granted last. last_grant advances only on upd_i.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   ifu_valid_i,
  input  logic   lsu_valid_i,
  input  logic   upd_i,
  output logic   gnt_valid_o,
  output owner_e gnt_o
);

  owner_e last_q;
  owner_e last_d;

  always_comb begin
    gnt_valid_o = ifu_valid_i | lsu_valid_i;
    gnt_o       = OWN_IFU;
    if (ifu_valid_i && lsu_valid_i) begin
      gnt_o = (last_q == OWN_IFU) ? OWN_LSU : OWN_IFU;
    end else if (lsu_valid_i) begin
      gnt_o = OWN_LSU;
    end
    last_d = upd_i ? gnt_o : last_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= OWN_IFU;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store,
// one transaction in flight, with a WAIT-state timeout that returns an error.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int ADDR_W  = 32,
  parameter  int DATA_W  = 32,
  parameter  int TIMEOUT = 255,
  localparam int MASK_W  = mask_width(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  output logic              if_rsp_err,
  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic              ls_wen,
  input  logic [DATA_W-1:0] ls_wdata,
  input  logic [MASK_W-1:0] ls_wmask,
  output logic              ls_rsp_valid,
  output logic [DATA_W-1:0] ls_rsp_data,
  output logic              ls_rsp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0]   wmask_q, wmask_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                if_rsp_valid_q, if_rsp_valid_d;
  logic [DATA_W-1:0]   if_rsp_data_q, if_rsp_data_d;
  logic                if_rsp_err_q, if_rsp_err_d;
  logic                ls_rsp_valid_q, ls_rsp_valid_d;
  logic [DATA_W-1:0]   ls_rsp_data_q, ls_rsp_data_d;
  logic                ls_rsp_err_q, ls_rsp_err_d;

  logic                arb_gnt_valid;
  owner_e              arb_gnt;
  logic                arb_upd;
  logic                rsp_fire;
  logic                rsp_err;
  logic [DATA_W-1:0]   rsp_data;

  rr_arb2 u_rr_arb2 (
    .clk         (clk),
    .rst         (rst),
    .ifu_valid_i (if_req_valid),
    .lsu_valid_i (ls_req_valid),
    .upd_i       (arb_upd),
    .gnt_valid_o (arb_gnt_valid),
    .gnt_o       (arb_gnt)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    wen_d    = wen_q;
    wdata_d  = wdata_q;
    wmask_d  = wmask_q;
    cnt_d    = cnt_q;
    arb_upd  = 1'b0;
    rsp_fire = 1'b0;
    rsp_err  = 1'b0;
    rsp_data = '0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (arb_gnt_valid) begin
          arb_upd = 1'b1;
          owner_d = arb_gnt;
          state_d = REQ;
          if (arb_gnt == OWN_LSU) begin
            addr_d  = ls_addr;
            wen_d   = ls_wen;
            wdata_d = ls_wdata;
            wmask_d = ls_wmask;
          end else begin
            addr_d  = if_addr;
            wen_d   = 1'b0;
            wdata_d = '0;
            wmask_d = '0;
          end
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        // A response landing on the timeout cycle still counts as success.
        if (mem_rsp_valid) begin
          rsp_fire = 1'b1;
          rsp_data = wen_q ? '0 : mem_rdata;
          state_d  = IDLE;
        end else if ((TIMEOUT > 0) && (cnt_q == CNT_LAST)) begin
          rsp_fire = 1'b1;
          rsp_err  = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    if_rsp_valid_d = rsp_fire && (owner_q == OWN_IFU);
    if_rsp_err_d   = if_rsp_valid_d && rsp_err;
    if_rsp_data_d  = if_rsp_valid_d ? rsp_data : if_rsp_data_q;
    ls_rsp_valid_d = rsp_fire && (owner_q == OWN_LSU);
    ls_rsp_err_d   = ls_rsp_valid_d && rsp_err;
    ls_rsp_data_d  = ls_rsp_valid_d ? rsp_data : ls_rsp_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      owner_q        <= OWN_IFU;
      addr_q         <= '0;
      wen_q          <= 1'b0;
      wdata_q        <= '0;
      wmask_q        <= '0;
      cnt_q          <= '0;
      if_rsp_valid_q <= 1'b0;
      if_rsp_data_q  <= '0;
      if_rsp_err_q   <= 1'b0;
      ls_rsp_valid_q <= 1'b0;
      ls_rsp_data_q  <= '0;
      ls_rsp_err_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      addr_q         <= addr_d;
      wen_q          <= wen_d;
      wdata_q        <= wdata_d;
      wmask_q        <= wmask_d;
      cnt_q          <= cnt_d;
      if_rsp_valid_q <= if_rsp_valid_d;
      if_rsp_data_q  <= if_rsp_data_d;
      if_rsp_err_q   <= if_rsp_err_d;
      ls_rsp_valid_q <= ls_rsp_valid_d;
      ls_rsp_data_q  <= ls_rsp_data_d;
      ls_rsp_err_q   <= ls_rsp_err_d;
    end
  end

  assign if_req_ready  = (state_q == IDLE) && arb_gnt_valid && (arb_gnt == OWN_IFU);
  assign ls_req_ready  = (state_q == IDLE) && arb_gnt_valid && (arb_gnt == OWN_LSU);
  assign mem_req_valid = (state_q == REQ);
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;
  assign if_rsp_valid  = if_rsp_valid_q;
  assign if_rsp_data   = if_rsp_data_q;
  assign if_rsp_err    = if_rsp_err_q;
  assign ls_rsp_valid  = ls_rsp_valid_q;
  assign ls_rsp_data   = ls_rsp_data_q;
  assign ls_rsp_err    = ls_rsp_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus randomized bench for mem_arbiter with TIMEOUT=4; expected
// grants and responses come from a transaction-level model of the arbiter rules.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 4;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req_valid, if_req_ready, if_rsp_valid, if_rsp_err;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rsp_data;
  logic          ls_req_valid, ls_req_ready, ls_wen, ls_rsp_valid, ls_rsp_err;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata, ls_rsp_data;
  logic [MW-1:0] ls_wmask;
  logic          mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [MW-1:0] mem_wmask;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
    .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data), .ls_rsp_err(ls_rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
  );

  int checks = 0;
  int errors = 0;
  int last_own = 0;                 // 0 = IFU, 1 = LSU
  logic [DW-1:0] exp_if_data = '0;
  logic [DW-1:0] exp_ls_data = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input bit ifv, input bit lsv, input int last);
    if (ifv && lsv) return 1 - last;
    return lsv ? 1 : 0;
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_if_rv"}, 64'(if_rsp_valid), 64'd0);
    chk({tag, "_ls_rv"}, 64'(ls_rsp_valid), 64'd0);
    chk({tag, "_if_rdy"}, 64'(if_req_ready), 64'd0);
    chk({tag, "_ls_rdy"}, 64'(ls_req_ready), 64'd0);
  endtask

  // Runs one transaction starting in IDLE with requester inputs already set.
  // rsp_at = WAIT cycle index of the memory response; >= TO means never.
  task automatic transact(input string tag, input int rdly, input int rsp_at,
                          input logic [DW-1:0] rd, input bit keep, output int g);
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_data;
    logic [MW-1:0] e_mask;
    logic          e_wen, e_err;
    g = pick(if_req_valid, ls_req_valid, last_own);
    #1;
    chk({tag, "_gnt_if"}, 64'(if_req_ready), 64'(g == 0));
    chk({tag, "_gnt_ls"}, 64'(ls_req_ready), 64'(g == 1));
    if (g == 0) begin
      e_addr = if_addr; e_wen = 1'b0; e_wdata = '0; e_mask = '0;
    end else begin
      e_addr = ls_addr; e_wen = ls_wen; e_wdata = ls_wdata; e_mask = ls_wmask;
    end
    tick();
    if (!keep) begin
      if (g == 0) if_req_valid = 1'b0;
      else ls_req_valid = 1'b0;
    end
    for (int i = 0; i <= rdly; i++) begin
      chk({tag, "_req_v"}, 64'(mem_req_valid), 64'd1);
      chk({tag, "_addr"}, 64'(mem_addr), 64'(e_addr));
      chk({tag, "_wen"}, 64'(mem_wen), 64'(e_wen));
      chk({tag, "_wdata"}, 64'(mem_wdata), 64'(e_wdata));
      chk({tag, "_wmask"}, 64'(mem_wmask), 64'(e_mask));
      chk_quiet({tag, "_req"});
      mem_req_ready = (i == rdly);
      mem_rsp_valid = 1'($urandom_range(0, 1));
      mem_rdata     = $urandom;
      tick();
    end
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    e_err  = 1'b1;
    e_data = '0;
    for (int w = 0; w < TO; w++) begin
      chk({tag, "_wait_rv"}, 64'(mem_req_valid), 64'd0);
      chk_quiet({tag, "_wait"});
      if (w == rsp_at) begin
        mem_rsp_valid = 1'b1;
        mem_rdata     = rd;
        e_err         = 1'b0;
        e_data        = e_wen ? '0 : rd;
      end
      tick();
      mem_rsp_valid = 1'b0;
      if (w == rsp_at) break;
    end
    chk({tag, "_rsp_if_v"}, 64'(if_rsp_valid), 64'(g == 0));
    chk({tag, "_rsp_ls_v"}, 64'(ls_rsp_valid), 64'(g == 1));
    if (g == 0) begin
      chk({tag, "_rsp_if_data"}, 64'(if_rsp_data), 64'(e_data));
      chk({tag, "_rsp_if_err"}, 64'(if_rsp_err), 64'(e_err));
      chk({tag, "_ls_hold"}, 64'(ls_rsp_data), 64'(exp_ls_data));
      chk({tag, "_ls_err0"}, 64'(ls_rsp_err), 64'd0);
      exp_if_data = e_data;
    end else begin
      chk({tag, "_rsp_ls_data"}, 64'(ls_rsp_data), 64'(e_data));
      chk({tag, "_rsp_ls_err"}, 64'(ls_rsp_err), 64'(e_err));
      chk({tag, "_if_hold"}, 64'(if_rsp_data), 64'(exp_if_data));
      chk({tag, "_if_err0"}, 64'(if_rsp_err), 64'd0);
      exp_ls_data = e_data;
    end
    last_own = g;
  endtask

  task automatic chk_all_zero(input string tag);
    chk_quiet(tag);
    chk({tag, "_if_data"}, 64'(if_rsp_data), 64'd0);
    chk({tag, "_ls_data"}, 64'(ls_rsp_data), 64'd0);
    chk({tag, "_if_err"}, 64'(if_rsp_err), 64'd0);
    chk({tag, "_ls_err"}, 64'(ls_rsp_err), 64'd0);
    chk({tag, "_req_v"}, 64'(mem_req_valid), 64'd0);
    chk({tag, "_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_wen"}, 64'(mem_wen), 64'd0);
    chk({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
    chk({tag, "_wmask"}, 64'(mem_wmask), 64'd0);
  endtask

  initial begin
    int g;
    int seq_exp [4] = '{1, 0, 1, 0};
    rst = 1'b1;
    if_req_valid = 1'b0; if_addr = '0;
    ls_req_valid = 1'b0; ls_addr = '0; ls_wen = 1'b0; ls_wdata = '0; ls_wmask = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
    repeat (3) tick();
    rst = 1'b0;
    chk_all_zero("reset");

    // Both requesters valid continuously: strict alternation, LSU first.
    if_req_valid = 1'b1; if_addr = 32'h0000_1000;
    ls_req_valid = 1'b1; ls_addr = 32'h0000_2000; ls_wen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      transact("rr", k % 2, 1, 32'hA000_0000 + k, 1'b1, g);
      chk("rr_seq", 64'(g), 64'(seq_exp[k]));
    end
    if_req_valid = 1'b0; ls_req_valid = 1'b0;

    // IFU fetch with best-case memory.
    if_req_valid = 1'b1; if_addr = 32'h8000_0000;
    transact("ifu", 0, 0, 32'h0010_0073, 1'b0, g);

    // LSU write with memory stalling the request for 3 cycles.
    ls_req_valid = 1'b1; ls_addr = 32'h8000_1000; ls_wen = 1'b1;
    ls_wdata = 32'hDEAD_BEEF; ls_wmask = 4'b0011;
    transact("lsw", 3, 1, 32'h1234_5678, 1'b0, g);

    // Memory never answers, then a normal request right after.
    ls_req_valid = 1'b1; ls_addr = 32'h8000_2000; ls_wen = 1'b0;
    transact("tmo", 1, 99, 32'h5555_AAAA, 1'b0, g);
    if_req_valid = 1'b1; if_addr = 32'h8000_0004;
    transact("post_tmo", 0, 2, 32'h0000_0013, 1'b0, g);

    // Response arriving on the timeout cycle wins.
    if_req_valid = 1'b1; if_addr = 32'h8000_0008;
    transact("tmo_edge", 0, TO - 1, 32'hCAFE_F00D, 1'b0, g);

    // Stray memory response while idle.
    mem_rsp_valid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    tick();
    mem_rsp_valid = 1'b0;
    chk_quiet("stray");
    chk("stray_req_v", 64'(mem_req_valid), 64'd0);

    for (int k = 0; k < 30; k++) begin
      bit a, b;
      a = 1'($urandom_range(0, 1));
      b = a ? 1'($urandom_range(0, 1)) : 1'b1;
      if_req_valid = a; ls_req_valid = b;
      if_addr = $urandom; ls_addr = $urandom; ls_wen = 1'($urandom_range(0, 1));
      ls_wdata = $urandom; ls_wmask = 4'($urandom_range(0, 15));
      transact("rnd", $urandom_range(0, 3), $urandom_range(0, 5), $urandom, 1'b0, g);
      if_req_valid = 1'b0; ls_req_valid = 1'b0;
      if ($urandom_range(0, 1) == 1) tick();
    end

    // Leave last_grant at LSU, then reset mid-WAIT and send a late response.
    ls_req_valid = 1'b1; ls_addr = 32'h8000_3000; ls_wen = 1'b0;
    transact("pre_rst", 0, 0, 32'h7777_1111, 1'b0, g);
    ls_req_valid = 1'b1; ls_addr = 32'h8000_4000; ls_wen = 1'b1;
    ls_wdata = 32'h0BAD_F00D; ls_wmask = 4'hF;
    tick();
    ls_req_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all_zero("rst_wait");
    mem_rsp_valid = 1'b1; mem_rdata = 32'h4444_4444;
    tick();
    mem_rsp_valid = 1'b0;
    chk_all_zero("late_rsp");
    last_own = 0; exp_if_data = '0; exp_ls_data = '0;
    if_req_valid = 1'b1; if_addr = 32'h8000_0010;
    ls_req_valid = 1'b1; ls_addr = 32'h8000_5000; ls_wen = 1'b0;
    transact("post_rst", 0, 1, 32'h9999_0000, 1'b0, g);
    chk("post_rst_tie", 64'(g), 64'd1);
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
